// File: rtl/ga25_pkg.sv
// Shared slot/state types and rowscroll constants for the GA25 VRAM scheduler.
package ga25_pkg;

  typedef enum logic [2:0] {
    SLOT_L0A     = 3'd0,
    SLOT_L0D     = 3'd1,
    SLOT_L1A     = 3'd2,
    SLOT_L1D     = 3'd3,
    SLOT_IDLE4   = 3'd4,
    SLOT_IDLE5   = 3'd5,
    SLOT_CPU     = 3'd6,
    SLOT_CPUDONE = 3'd7
  } slot_t;

  typedef enum logic [1:0] {
    CPU_IDLE   = 2'd0,
    CPU_PEND   = 2'd1,
    CPU_ISSUED = 2'd2
  } cpu_state_t;

  localparam logic [14:0] RS_DUMMY_ADDR = 15'h7800;
  localparam logic [14:0] RS_L1_OFS     = 15'h0200;
  localparam logic [14:0] RS_L2_OFS     = 15'h0400;

  localparam logic [3:0] BURST_DUMMY0   = 4'd0;
  localparam logic [3:0] BURST_RS0_ADDR = 4'd4;
  localparam logic [3:0] BURST_RS0_DATA = 4'd7;
  localparam logic [3:0] BURST_RS1_ADDR = 4'd8;
  localparam logic [3:0] BURST_RS1_DATA = 4'd10;
  localparam logic [3:0] BURST_DUMMY2   = 4'd12;
  localparam logic [3:0] BURST_END      = 4'd15;

  // Row index into a 512-entry rowscroll table; the 10-bit sum wraps and bit 9 is dropped.
  function automatic logic [14:0] rs_addr(input logic [14:0] table_base,
                                          input logic [9:0]  y_ofs,
                                          input logic [9:0]  line);
    logic [9:0] sum;
    sum = y_ofs + line;
    return table_base + 15'(sum & 10'h1ff);
  endfunction

endpackage

// File: rtl/ga25_vram_sched.sv
// GA25 VRAM time-division scheduler: 8-slot layer/CPU cycle plus a 16-step
// per-line rowscroll burst, with a busy handshake toward the CPU bus.
module ga25_vram_sched
  import ga25_pkg::*;
#(
  parameter logic [14:0] RS_BASE = 15'h7a00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        hpulse,
  input  logic [9:0]  ve,
  input  logic [9:0]  y_ofs0,
  input  logic [9:0]  y_ofs1,
  input  logic [14:0] layer_addr0,
  input  logic [14:0] layer_addr1,
  input  logic        mem_cs,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [14:0] addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        busy,
  output logic [14:0] vram_addr,
  output logic [15:0] vram_data,
  output logic        vram_we,
  input  logic [15:0] vram_q,
  output logic [1:0]  layer_load,
  output logic [15:0] index_latch,
  output logic [9:0]  rowscroll0,
  output logic [9:0]  rowscroll1
);

  slot_t      slot;
  cpu_state_t cpu_state;
  logic       is_write;
  logic       prev_access;
  logic       rs_pending;
  logic       rs_active;
  logic [3:0] burst_cnt;

  logic access;
  logic capture;

  assign access  = mem_cs & (mem_rd | mem_wr);
  assign capture = access & ~prev_access & (cpu_state == CPU_IDLE);
  assign busy    = (cpu_state != CPU_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot        <= SLOT_L0A;
      cpu_state   <= CPU_IDLE;
      is_write    <= 1'b0;
      prev_access <= 1'b0;
      rs_pending  <= 1'b0;
      rs_active   <= 1'b0;
      burst_cnt   <= '0;
      cpu_dout    <= '0;
      vram_addr   <= '0;
      vram_data   <= '0;
      vram_we     <= 1'b0;
      layer_load  <= '0;
      index_latch <= '0;
      rowscroll0  <= '0;
      rowscroll1  <= '0;
    end else begin
      vram_we     <= 1'b0;
      prev_access <= access;

      // CPU capture runs every clk; slot actions below only touch PEND/ISSUED states.
      if (capture) begin
        cpu_state <= CPU_PEND;
        is_write  <= mem_wr;
      end

      if (ce) begin
        layer_load <= '0;
        slot       <= slot_t'(slot + 3'd1);

        if (rs_active) begin
          burst_cnt <= burst_cnt + 4'd1;
          case (burst_cnt)
            BURST_DUMMY0:   vram_addr  <= RS_DUMMY_ADDR;
            BURST_RS0_ADDR: vram_addr  <= rs_addr(RS_BASE, y_ofs0, ve);
            BURST_RS0_DATA: rowscroll0 <= vram_q[9:0];
            BURST_RS1_ADDR: vram_addr  <= rs_addr(RS_BASE + RS_L1_OFS, y_ofs1, ve);
            BURST_RS1_DATA: rowscroll1 <= vram_q[9:0];
            BURST_DUMMY2:   vram_addr  <= rs_addr(RS_BASE + RS_L2_OFS, y_ofs1, ve);
            BURST_END:      rs_active  <= 1'b0;
            default: ;
          endcase
        end else begin
          case (slot)
            SLOT_L0A: vram_addr <= layer_addr0;
            SLOT_L0D: begin
              index_latch  <= vram_q;
              vram_addr[0] <= 1'b1;
              layer_load   <= 2'b01;
            end
            SLOT_L1A: vram_addr <= layer_addr1;
            SLOT_L1D: begin
              index_latch  <= vram_q;
              vram_addr[0] <= 1'b1;
              layer_load   <= 2'b10;
            end
            SLOT_CPU: begin
              if (cpu_state == CPU_PEND) begin
                vram_addr <= addr;
                vram_data <= cpu_din;
                vram_we   <= is_write;
                cpu_state <= CPU_ISSUED;
              end
            end
            SLOT_CPUDONE: begin
              if (cpu_state == CPU_ISSUED) begin
                cpu_dout  <= vram_q;
                cpu_state <= CPU_IDLE;
              end
              if (rs_pending) begin
                rs_pending <= 1'b0;
                rs_active  <= 1'b1;
                burst_cnt  <= '0;
              end
            end
            default: ;
          endcase
        end

        // Placed last so a line start on the burst-launch ce re-arms the next burst.
        if (hpulse) begin
          slot       <= SLOT_CPUDONE;
          rs_pending <= 1'b1;
        end
      end
    end
  end

endmodule
